part_2_targ_xchg: RTL and testbench
===================================

PART_2_TARG_XCHG -- requirements
Module: part_2_targ_xchg

Interface
REQ-001 SHALL have parameter N, default 9, meaning exchanged vector width ({wen/valid, 8-bit data}).
REQ-002 SHALL have parameter RX_IDX, default 0, meaning signal index of vectors the initiator sends.
REQ-003 SHALL have parameter TX_IDX, default 3, meaning signal index stamped on vectors returned to the initiator.
REQ-004 SHALL have parameter WDOG_MAX, default 10000, meaning clk_i cycles allowed in WAIT_VEC before error.
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port clk_i  in  1  utility clock.
REQ-007 SHALL have port rst_ni  in  1  asynchronous active-low reset.
REQ-008 SHALL have port clk_0_h  in  1  target mission clock, sampled in clk_i.
REQ-009 SHALL have ports rx_valid in 1, rx_idx in 2, rx_data in N, rx_ready out 1: inbound vectors from the transport.
REQ-010 SHALL have ports tx_valid out 1, tx_ready in 1, tx_idx out 2, tx_data out N: outbound vectors to the transport.
REQ-011 SHALL have ports sut_wen out 1 and sut_data out 8: unpacked vector applied to the target partition.
REQ-012 SHALL have ports sut_valid in 1 and sut_o_data in 8: target partition response.
REQ-013 SHALL have ports freeze_clk out 1 (hold mission clock generator), wdog_err out 1 (sticky), ovr_err out 1 (sticky), drop_cnt out 8.

Function
REQ-014 SHALL register clk_0_h into clk_0_h_d and define edge = clk_0_h & !clk_0_h_d.
REQ-015 SHALL hold received vectors in a one-entry slot; rx_ready = !slot_full; a transfer occurs when rx_valid & rx_ready.
REQ-016 SHALL store a transfer with rx_idx == RX_IDX into the slot; any other index SHALL be discarded and increment drop_cnt, saturating at 255.
REQ-017 SHALL implement FSM states IDLE, WAIT_VEC, APPLY, SEND, ERROR.
REQ-018 SHALL transition IDLE -> WAIT_VEC on edge or on pending flag set; entering WAIT_VEC clears the pending flag and zeroes the watchdog.
REQ-019 In WAIT_VEC with slot full, SHALL consume the slot, latch its data, and go to APPLY.
REQ-020 In WAIT_VEC with slot empty, SHALL increment the watchdog; at watchdog == WDOG_MAX-1 it SHALL go to ERROR.
REQ-021 SHALL assert sut_wen = latched[8] and sut_data = latched[7:0] for exactly the one clk_i cycle spent in APPLY; otherwise sut_wen = 0 and sut_data holds its last value.
REQ-022 On leaving APPLY, SHALL capture {sut_valid, sut_o_data} into tx_data and go to SEND.
REQ-023 In SEND, SHALL assert tx_valid with tx_idx = TX_IDX and hold tx_data stable until tx_ready; on handshake it SHALL go to IDLE.
REQ-024 An edge seen outside IDLE SHALL set a one-deep pending flag; an edge while the flag is already set SHALL set ovr_err and leave the flag set.
REQ-025 SHALL drive freeze_clk = (WAIT_VEC & !slot_full) | ERROR, combinationally.
REQ-026 ERROR SHALL be terminal until reset, with wdog_err = 1, tx_valid = 0, sut_wen = 0; rx_ready keeps following the slot.
REQ-027 SHALL give a latency, with slot prefilled and edge in cycle n, of WAIT_VEC at n+1, sut_wen high at n+2, and tx_valid high from n+3.

Reset
REQ-028 While rst_ni = 0, SHALL hold state = IDLE and clear the slot, pending flag, watchdog, clk_0_h_d, sut_wen, sut_data, tx_valid, tx_data, wdog_err, ovr_err, and drop_cnt; tx_idx = TX_IDX and freeze_clk = 0.
REQ-029 Reset asserted mid-SEND SHALL drop tx_valid immediately, and the vector SHALL be lost.

Structure
REQ-030 SHALL take the state enum and the N, index, and WDOG_MAX defaults from shared package part_xchg_pkg.
REQ-031 SHALL instantiate sub-module part_xchg_rx_slot for the one-entry slot with index filter and drop counter.

Verification
REQ-032 Bench SHALL cover: slot preloaded with {1,0xA5}, then edge -> sut_wen = 1 and sut_data = 0xA5 at n+2; with sut response {1,0x3C}, tx_data = 0x13C and tx_idx = 3 at n+3.
REQ-033 Bench SHALL cover: edge with no rx, vector arriving 50 cycles later -> freeze_clk high for those 50 cycles, low in the consume cycle, then normal response.
REQ-034 Bench SHALL cover: edge with no rx and WDOG_MAX = 16 -> ERROR after 16 WAIT_VEC cycles, wdog_err = 1 and freeze_clk = 1 until reset.
REQ-035 Bench SHALL cover: rx with rx_idx = 2 three times -> drop_cnt = 3 and slot stays empty; 300 drops -> drop_cnt = 255.
REQ-036 Bench SHALL cover: tx_ready low, two edges during SEND -> first edge sets pending and the FSM re-enters WAIT_VEC after the handshake; second edge sets ovr_err = 1.
REQ-037 Bench SHALL cover: rst_ni pulsed low during SEND -> tx_valid = 0 in the same cycle, and all outputs take their REQ-028 values.

Source files
------------

// File: rtl/part_xchg_pkg.sv
// Shared types and defaults for the target-side vector exchange.
package part_xchg_pkg;

  localparam int XCHG_N       = 9;      // {wen/valid, 8-bit data}
  localparam int RX_IDX_DEF   = 0;
  localparam int TX_IDX_DEF   = 3;
  localparam int WDOG_MAX_DEF = 10000;
  localparam int IDX_W        = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_VEC,
    ST_APPLY,
    ST_SEND,
    ST_ERROR
  } xchg_state_e;

endpackage

// File: rtl/part_xchg_rx_slot.sv
// One-entry inbound vector slot with index filter and saturating drop counter.
module part_xchg_rx_slot
  import part_xchg_pkg::*;
#(
  parameter int N      = XCHG_N,
  parameter int RX_IDX = RX_IDX_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             rx_valid,
  input  logic [IDX_W-1:0] rx_idx,
  input  logic [N-1:0]     rx_data,
  output logic             rx_ready,
  input  logic             consume,
  output logic             slot_full,
  output logic [N-1:0]     slot_data,
  output logic [7:0]       drop_cnt
);

  localparam logic [IDX_W-1:0] RX_IDX_L = IDX_W'(RX_IDX);

  logic         full_q, full_d;
  logic [N-1:0] data_q, data_d;
  logic [7:0]   drop_q, drop_d;
  logic         xfer;

  assign rx_ready  = !full_q;
  assign xfer      = rx_valid && !full_q;
  assign slot_full = full_q;
  assign slot_data = data_q;
  assign drop_cnt  = drop_q;

  // Accept matching vectors into the slot, count and discard the rest.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    drop_d = drop_q;
    if (consume) full_d = 1'b0;
    if (xfer) begin
      if (rx_idx == RX_IDX_L) begin
        full_d = 1'b1;
        data_d = rx_data;
      end else if (drop_q != 8'hFF) begin
        drop_d = drop_q + 8'd1;
      end
    end
  end

  // Slot and counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
      data_q <= '0;
      drop_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      drop_q <= drop_d;
    end
  end

endmodule

// File: rtl/part_2_targ_xchg.sv
// Target-side exchange: on each mission clock edge, wait for an initiator
// vector, apply it to the partition for one cycle, and return the response.
module part_2_targ_xchg
  import part_xchg_pkg::*;
#(
  parameter int N        = XCHG_N,
  parameter int RX_IDX   = RX_IDX_DEF,
  parameter int TX_IDX   = TX_IDX_DEF,
  parameter int WDOG_MAX = WDOG_MAX_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clk_0_h,
  input  logic             rx_valid,
  input  logic [IDX_W-1:0] rx_idx,
  input  logic [N-1:0]     rx_data,
  output logic             rx_ready,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [IDX_W-1:0] tx_idx,
  output logic [N-1:0]     tx_data,
  output logic             sut_wen,
  output logic [7:0]       sut_data,
  input  logic             sut_valid,
  input  logic [7:0]       sut_o_data,
  output logic             freeze_clk,
  output logic             wdog_err,
  output logic             ovr_err,
  output logic [7:0]       drop_cnt
);

  localparam int WDOG_W = $clog2(WDOG_MAX + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_MAX - 1);

  xchg_state_e       state_q, state_d;
  logic              clk_0_h_q;     // one-cycle delayed mission clock
  logic              pend_q, pend_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              ovr_q, ovr_d;
  logic              sut_wen_q, sut_wen_d;
  logic [7:0]        sut_data_q, sut_data_d;
  logic [N-1:0]      tx_data_q, tx_data_d;
  logic              mis_edge;
  logic              consume;
  logic              slot_full;
  logic [N-1:0]      slot_data;

  part_xchg_rx_slot #(.N(N), .RX_IDX(RX_IDX)) u_slot (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .rx_valid  (rx_valid),
    .rx_idx    (rx_idx),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .consume   (consume),
    .slot_full (slot_full),
    .slot_data (slot_data),
    .drop_cnt  (drop_cnt)
  );

  assign mis_edge   = clk_0_h && !clk_0_h_q;
  assign tx_valid   = (state_q == ST_SEND);
  assign tx_idx     = IDX_W'(TX_IDX);
  assign tx_data    = tx_data_q;
  assign sut_wen    = sut_wen_q;
  assign sut_data   = sut_data_q;
  assign wdog_err   = (state_q == ST_ERROR);
  assign ovr_err    = ovr_q;
  assign freeze_clk = ((state_q == ST_WAIT_VEC) && !slot_full) || (state_q == ST_ERROR);

  // Exchange FSM: next state, pending/overrun tracking, watchdog, datapath loads.
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    wdog_d     = wdog_q;
    ovr_d      = ovr_q;
    sut_wen_d  = 1'b0;
    sut_data_d = sut_data_q;
    tx_data_d  = tx_data_q;
    consume    = 1'b0;

    // Edges while busy are remembered once; a second one is an overrun.
    if (mis_edge && (state_q != ST_IDLE)) begin
      if (pend_q) ovr_d = 1'b1;
      else        pend_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (mis_edge || pend_q) begin
          state_d = ST_WAIT_VEC;
          pend_d  = 1'b0;
          wdog_d  = '0;
        end
      end
      ST_WAIT_VEC: begin
        if (slot_full) begin
          consume    = 1'b1;
          sut_wen_d  = slot_data[8];
          sut_data_d = slot_data[7:0];
          state_d    = ST_APPLY;
        end else if (wdog_q == WDOG_LAST) begin
          state_d = ST_ERROR;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      ST_APPLY: begin
        tx_data_d = N'({sut_valid, sut_o_data});
        state_d   = ST_SEND;
      end
      ST_SEND: begin
        if (tx_ready) state_d = ST_IDLE;
      end
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      clk_0_h_q  <= 1'b0;
      pend_q     <= 1'b0;
      wdog_q     <= '0;
      ovr_q      <= 1'b0;
      sut_wen_q  <= 1'b0;
      sut_data_q <= '0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      clk_0_h_q  <= clk_0_h;
      pend_q     <= pend_d;
      wdog_q     <= wdog_d;
      ovr_q      <= ovr_d;
      sut_wen_q  <= sut_wen_d;
      sut_data_q <= sut_data_d;
      tx_data_q  <= tx_data_d;
    end
  end

endmodule

// File: tb/tb_part_2_targ_xchg.sv
// Directed bench for part_2_targ_xchg: latency, stall, watchdog, drops,
// overrun and reset-during-send.
module tb_part_2_targ_xchg;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       clk_0_h = 1'b0;
  logic       rx_valid = 1'b0;
  logic [1:0] rx_idx = 2'd0;
  logic [8:0] rx_data = '0;
  logic       tx_ready = 1'b0;
  logic       sut_valid = 1'b0;
  logic [7:0] sut_o_data = '0;
  logic       rx_ready, tx_valid, sut_wen, freeze_clk, wdog_err, ovr_err;
  logic [1:0] tx_idx;
  logic [8:0] tx_data;
  logic [7:0] sut_data, drop_cnt;

  // watchdog instance (WDOG_MAX = 16) with its own mission clock, no rx traffic
  logic       b_clk_0_h = 1'b0;
  logic       b_rx_valid = 1'b0;
  logic       b_rx_ready, b_tx_valid, b_sut_wen, b_freeze, b_wdog_err, b_ovr_err;
  logic [1:0] b_tx_idx;
  logic [8:0] b_tx_data;
  logic [7:0] b_sut_data, b_drop_cnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  part_2_targ_xchg dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clk_0_h(clk_0_h),
    .rx_valid(rx_valid), .rx_idx(rx_idx), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_idx(tx_idx), .tx_data(tx_data),
    .sut_wen(sut_wen), .sut_data(sut_data), .sut_valid(sut_valid), .sut_o_data(sut_o_data),
    .freeze_clk(freeze_clk), .wdog_err(wdog_err), .ovr_err(ovr_err), .drop_cnt(drop_cnt)
  );

  part_2_targ_xchg #(.WDOG_MAX(16)) dut_wd (
    .clk_i(clk_i), .rst_ni(rst_ni), .clk_0_h(b_clk_0_h),
    .rx_valid(b_rx_valid), .rx_idx(rx_idx), .rx_data(rx_data), .rx_ready(b_rx_ready),
    .tx_valid(b_tx_valid), .tx_ready(tx_ready), .tx_idx(b_tx_idx), .tx_data(b_tx_data),
    .sut_wen(b_sut_wen), .sut_data(b_sut_data), .sut_valid(sut_valid), .sut_o_data(sut_o_data),
    .freeze_clk(b_freeze), .wdog_err(b_wdog_err), .ovr_err(b_ovr_err), .drop_cnt(b_drop_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // advance one clk_i cycle; sample point is 1 time unit after the edge
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".tx_valid"}, 32'(tx_valid), 0);
    chk({tag, ".tx_idx"},   32'(tx_idx), 3);
    chk({tag, ".tx_data"},  32'(tx_data), 0);
    chk({tag, ".sut_wen"},  32'(sut_wen), 0);
    chk({tag, ".sut_data"}, 32'(sut_data), 0);
    chk({tag, ".freeze"},   32'(freeze_clk), 0);
    chk({tag, ".wdog_err"}, 32'(wdog_err), 0);
    chk({tag, ".ovr_err"},  32'(ovr_err), 0);
    chk({tag, ".drop_cnt"}, 32'(drop_cnt), 0);
    chk({tag, ".rx_ready"}, 32'(rx_ready), 1);
  endtask

  // present one rx beat for a single cycle
  task automatic send_rx(input logic [1:0] idx, input logic [8:0] data);
    rx_valid = 1'b1; rx_idx = idx; rx_data = data;
    step();
    rx_valid = 1'b0;
  endtask

  initial begin
    step(); step();
    rst_ni = 1'b1;
    chk_reset_vals("rst");

    // ---- watchdog: 16 WAIT_VEC cycles then terminal ERROR ----
    b_clk_0_h = 1'b1; step(); b_clk_0_h = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (b_wdog_err !== 1'b0 || b_freeze !== 1'b1) chk("wd.wait", {30'd0, b_wdog_err, b_freeze}, 32'b01);
      step();
    end
    chk("wd.err", 32'(b_wdog_err), 1);
    chk("wd.freeze", 32'(b_freeze), 1);
    chk("wd.txv", 32'(b_tx_valid), 0);
    b_clk_0_h = 1'b1; step(); b_clk_0_h = 1'b0; step(); step();
    chk("wd.sticky", 32'(b_wdog_err), 1);
    chk("wd.rxrdy", 32'(b_rx_ready), 1);

    // ---- prefilled slot latency: sut at n+2, tx at n+3 ----
    send_rx(2'd0, 9'h1A5);
    chk("lat.full", 32'(rx_ready), 0);
    sut_valid = 1'b1; sut_o_data = 8'h3C;
    clk_0_h = 1'b1; step(); clk_0_h = 1'b0;      // n+1 WAIT_VEC
    chk("lat.n1.freeze", 32'(freeze_clk), 0);
    chk("lat.n1.wen", 32'(sut_wen), 0);
    step();                                        // n+2 APPLY
    chk("lat.n2.wen", 32'(sut_wen), 1);
    chk("lat.n2.data", 32'(sut_data), 32'hA5);
    chk("lat.n2.txv", 32'(tx_valid), 0);
    step();                                        // n+3 SEND
    chk("lat.n3.txv", 32'(tx_valid), 1);
    chk("lat.n3.txd", 32'(tx_data), 32'h13C);
    chk("lat.n3.idx", 32'(tx_idx), 3);
    chk("lat.n3.wen", 32'(sut_wen), 0);
    chk("lat.n3.hold", 32'(sut_data), 32'hA5);
    step();
    chk("lat.stall", 32'(tx_data), 32'h13C);
    tx_ready = 1'b1; step(); tx_ready = 1'b0;
    chk("lat.done", 32'(tx_valid), 0);

    // ---- stall: vector arrives 50 cycles after the edge ----
    sut_valid = 1'b0; sut_o_data = 8'h77;
    clk_0_h = 1'b1; step(); clk_0_h = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (freeze_clk !== 1'b1) chk("stall.freeze", 32'(freeze_clk), 1);
      if (i == 49) begin rx_valid = 1'b1; rx_idx = 2'd0; rx_data = 9'h15A; end
      step();
    end
    rx_valid = 1'b0;
    chk("stall.consume", 32'(freeze_clk), 0);
    step();
    chk("stall.wen", 32'(sut_wen), 1);
    chk("stall.data", 32'(sut_data), 32'h5A);
    step();
    chk("stall.txd", 32'(tx_data), 32'h077);
    tx_ready = 1'b1; step(); tx_ready = 1'b0;

    // ---- index filter and drop counter saturation ----
    for (int i = 0; i < 3; i++) send_rx(2'd2, 9'h0FF);
    chk("drop.3", 32'(drop_cnt), 3);
    chk("drop.empty", 32'(rx_ready), 1);
    for (int i = 0; i < 297; i++) send_rx(2'd1, 9'h011);
    chk("drop.sat", 32'(drop_cnt), 255);
    chk("drop.idle", 32'(freeze_clk), 0);

    // ---- pending edge and overrun while stuck in SEND ----
    send_rx(2'd0, 9'h001);
    sut_valid = 1'b1; sut_o_data = 8'h42;
    clk_0_h = 1'b1; step(); clk_0_h = 1'b0;
    step(); step();
    chk("ovr.send", 32'(tx_valid), 1);
    clk_0_h = 1'b1; step(); clk_0_h = 1'b0; step();
    chk("ovr.first", 32'(ovr_err), 0);
    clk_0_h = 1'b1; step(); clk_0_h = 1'b0;
    chk("ovr.second", 32'(ovr_err), 1);
    chk("ovr.txhold", 32'(tx_data), 32'h142);
    tx_ready = 1'b1; step(); tx_ready = 1'b0;
    chk("ovr.idle", 32'(tx_valid), 0);
    step();
    chk("ovr.rewait", 32'(freeze_clk), 1);

    // ---- reset asserted mid-SEND ----
    send_rx(2'd0, 9'h1EE);                         // consumed by pending WAIT_VEC
    step(); step();
    chk("rs.send", 32'(tx_valid), 1);
    chk("rs.pre.drop", 32'(drop_cnt), 255);
    #2 rst_ni = 1'b0;
    #1;
    chk_reset_vals("rs");
    chk("rs.wd.err", 32'(b_wdog_err), 0);
    chk("rs.wd.freeze", 32'(b_freeze), 0);
    step();
    rst_ni = 1'b1;
    step(); step();
    chk("rs.lost", 32'(tx_valid), 0);
    chk("rs.idle", 32'(freeze_clk), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
